// File: rtl/adc_avg_regbank.sv
// Per-channel ADC sample averager with a small byte-wide register bank.
// Accumulates 2^AVG_LOG2 sequencer rounds per channel, then publishes truncated averages.
module adc_avg_regbank #(
    parameter int                    NUM_CH    = 5,
    parameter int                    DATA_W    = 12,
    parameter int                    AVG_LOG2  = 2,
    parameter logic [5*NUM_CH-1:0]   CH_IDS    = {5'd6, 5'd4, 5'd3, 5'd2, 5'd1},
    parameter logic [DATA_W-1:0]     ALARM_THR = '0
) (
    input  logic              in_CLK,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              st_valid,
    input  logic [4:0]        st_channel,
    input  logic [DATA_W-1:0] st_data,
    input  logic              st_eop,
    input  logic              rd_en,
    input  logic [7:0]        rd_addr,
    output logic [7:0]        rd_data,
    output logic              sample_tick,
    output logic [NUM_CH-1:0] alarm
);

    localparam int         ACC_W      = DATA_W + AVG_LOG2;
    localparam logic [5:0] LAST_ROUND = 6'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0]  r_acc     [NUM_CH];
    logic [DATA_W-1:0] r_avg     [NUM_CH];
    logic [7:0]        r_shadow  [NUM_CH];
    logic [5:0]        r_round;
    logic [7:0]        r_pub_cnt;
    logic              r_tick;
    logic [NUM_CH-1:0] r_alarm;
    logic [7:0]        r_rd_data;

    logic              w_beat;
    logic              w_publish;
    logic [NUM_CH-1:0] w_match;
    logic [ACC_W-1:0]  w_sum     [NUM_CH];
    logic [DATA_W-1:0] w_new_avg [NUM_CH];
    logic [15:0]       w_avg_ext [NUM_CH];
    logic [7:0]        w_rd_next;
    logic [NUM_CH-1:0] w_shadow_ld;

    assign w_beat    = enable && st_valid;
    assign w_publish = w_beat && st_eop && (r_round == LAST_ROUND);

    // The publishing beat's own sample is folded into the average it closes.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_match[i]   = w_beat && (st_channel == CH_IDS[5*i +: 5]);
            w_sum[i]     = r_acc[i] + (w_match[i] ? ACC_W'(st_data) : '0);
            w_new_avg[i] = DATA_W'(w_sum[i] >> AVG_LOG2);
            w_avg_ext[i] = 16'(r_avg[i]);
        end
    end

    always_comb begin
        w_rd_next   = 8'h00;
        w_shadow_ld = '0;
        if (rd_addr == 8'h00) w_rd_next = r_pub_cnt;
        if (rd_addr == 8'h01) w_rd_next = {7'b0, enable};
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_addr == 8'(2 + 2*i)) begin
                w_rd_next      = w_avg_ext[i][7:0];
                w_shadow_ld[i] = 1'b1;
            end
            if (rd_addr == 8'(3 + 2*i)) w_rd_next = r_shadow[i];
        end
    end

    always_ff @(posedge in_CLK or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i]    <= '0;
                r_avg[i]    <= '0;
                r_shadow[i] <= '0;
            end
            r_round   <= '0;
            r_pub_cnt <= '0;
            r_tick    <= 1'b0;
            r_alarm   <= '0;
            r_rd_data <= '0;
        end else begin
            r_tick <= w_publish;
            if (!enable) begin
                for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
                r_round <= '0;
            end else if (w_publish) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    r_acc[i]   <= '0;
                    r_avg[i]   <= w_new_avg[i];
                    r_alarm[i] <= (w_new_avg[i] < ALARM_THR);
                end
                r_round   <= '0;
                r_pub_cnt <= r_pub_cnt + 8'd1;
            end else begin
                for (int i = 0; i < NUM_CH; i++) r_acc[i] <= w_sum[i];
                if (w_beat && st_eop) r_round <= r_round + 6'd1;
            end
            // Reads see pre-publish values because they sample the current registers.
            if (rd_en) begin
                r_rd_data <= w_rd_next;
                for (int i = 0; i < NUM_CH; i++)
                    if (w_shadow_ld[i]) r_shadow[i] <= w_avg_ext[i][15:8];
            end
        end
    end

    assign rd_data     = r_rd_data;
    assign sample_tick = r_tick;
    assign alarm       = r_alarm;

endmodule

// File: tb/tb_adc_avg_regbank.sv
// Directed bench for adc_avg_regbank: averaging, truncation, shadow reads, enable drop,
// alarms, publish counter wrap and mid-round reset.
module tb_adc_avg_regbank;

    logic        in_CLK;
    logic        reset_n;
    logic        enable;
    logic        st_valid;
    logic [4:0]  st_channel;
    logic [11:0] st_data;
    logic        st_eop;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        sample_tick;
    logic [4:0]  alarm;

    int n_cmp = 0;
    int n_err = 0;

    adc_avg_regbank #(.ALARM_THR(12'h100)) dut (
        .in_CLK      (in_CLK),
        .reset_n     (reset_n),
        .enable      (enable),
        .st_valid    (st_valid),
        .st_channel  (st_channel),
        .st_data     (st_data),
        .st_eop      (st_eop),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .sample_tick (sample_tick),
        .alarm       (alarm)
    );

    initial in_CLK = 1'b0;
    always #5 in_CLK = ~in_CLK;

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [4:0] ch, input logic [11:0] d, input logic eop);
        st_valid   = 1'b1;
        st_channel = ch;
        st_data    = d;
        st_eop     = eop;
        @(posedge in_CLK);
        #1;
        st_valid = 1'b0;
        st_eop   = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        rd_en   = 1'b1;
        rd_addr = a;
        @(posedge in_CLK);
        #1;
        rd_en = 1'b0;
        d     = rd_data;
    endtask

    initial begin
        logic [7:0] d;
        int ticks;
        reset_n    = 1'b0;
        enable     = 1'b0;
        st_valid   = 1'b0;
        st_channel = '0;
        st_data    = '0;
        st_eop     = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        repeat (2) @(posedge in_CLK);
        #1;
        check("reset_rd_data", rd_data, 8'h00);
        check("reset_tick", sample_tick, 1'b0);
        check("reset_alarm", alarm, 5'h00);
        reset_n = 1'b1;
        enable  = 1'b1;
        @(posedge in_CLK);
        #1;

        // Average, truncation and absent channels
        beat(5'd2, 12'd1, 1'b0);
        beat(5'd3, 12'h400, 1'b0);
        beat(5'd1, 12'd100, 1'b1);
        check("tick_round0", sample_tick, 1'b0);
        beat(5'd2, 12'd1, 1'b0);
        beat(5'd1, 12'd200, 1'b1);
        beat(5'd2, 12'd1, 1'b0);
        beat(5'd1, 12'd300, 1'b1);
        check("tick_round2", sample_tick, 1'b0);
        beat(5'd2, 12'd2, 1'b0);
        beat(5'd1, 12'd400, 1'b1);
        check("tick_publish", sample_tick, 1'b1);
        @(posedge in_CLK);
        #1;
        check("tick_one_cycle", sample_tick, 1'b0);
        check("alarm_a", alarm, 5'b11011);
        rd(8'h02, d); check("avg0_lo_a", d, 8'hFA);
        @(posedge in_CLK);
        #1;
        check("rd_hold", rd_data, 8'hFA);
        rd(8'h03, d); check("avg0_hi_a", d, 8'h00);
        rd(8'h00, d); check("pubcnt_a", d, 8'h01);
        rd(8'h01, d); check("enable_reg", d, 8'h01);
        rd(8'h04, d); check("avg1_lo_a", d, 8'h01);
        rd(8'h06, d); check("avg2_lo_a", d, 8'h00);
        rd(8'h07, d); check("avg2_hi_a", d, 8'h01);
        rd(8'h08, d); check("avg3_lo_a", d, 8'h00);
        rd(8'h20, d); check("unmapped_0x20", d, 8'h00);

        // Shadow high byte; id 5 beats are ignored
        for (int r = 0; r < 4; r++) begin
            beat(5'd5, 12'hFFF, 1'b0);
            beat(5'd1, 12'h1FF, 1'b1);
        end
        check("alarm_b", alarm, 5'b11110);
        rd(8'h02, d); check("avg0_lo_b", d, 8'hFF);
        for (int r = 0; r < 4; r++) beat(5'd1, 12'h200, 1'b1);
        rd(8'h03, d); check("shadow_stale", d, 8'h01);
        rd(8'h02, d); check("avg0_lo_c", d, 8'h00);
        rd(8'h03, d); check("shadow_fresh", d, 8'h02);
        rd(8'h00, d); check("pubcnt_c", d, 8'h03);

        // Enable drop discards a partial average
        beat(5'd1, 12'h800, 1'b1);
        beat(5'd1, 12'h800, 1'b1);
        enable = 1'b0;
        rd(8'h01, d); check("enable_low_reg", d, 8'h00);
        enable = 1'b1;
        for (int r = 0; r < 4; r++) beat(5'd1, 12'h010, 1'b1);
        check("tick_after_drop", sample_tick, 1'b1);
        rd(8'h02, d); check("avg0_lo_drop", d, 8'h10);
        rd(8'h03, d); check("avg0_hi_drop", d, 8'h00);
        rd(8'h00, d); check("pubcnt_drop", d, 8'h04);

        // Publish counter wrap (4 + 252 = 256)
        ticks = 0;
        for (int p = 0; p < 252; p++) begin
            for (int r = 0; r < 4; r++) begin
                beat(5'd0, 12'hABC, 1'b1);
                if (sample_tick) ticks++;
            end
        end
        check("wrap_ticks", ticks, 252);
        rd(8'h00, d); check("pubcnt_wrap", d, 8'h00);
        check("alarm_zero_avg", alarm, 5'b11111);

        // Mid-round reset
        for (int r = 0; r < 4; r++) beat(5'd1, 12'h803, 1'b1);
        rd(8'h02, d); check("avg0_lo_e", d, 8'h03);
        rd(8'h00, d); check("pubcnt_e", d, 8'h01);
        beat(5'd1, 12'h800, 1'b1);
        beat(5'd1, 12'h800, 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rd_data", rd_data, 8'h00);
        check("async_tick", sample_tick, 1'b0);
        check("async_alarm", alarm, 5'h00);
        @(negedge in_CLK);
        reset_n = 1'b1;
        @(posedge in_CLK);
        #1;
        rd(8'h03, d); check("post_rst_shadow", d, 8'h00);
        rd(8'h02, d); check("post_rst_avg0", d, 8'h00);
        rd(8'h00, d); check("post_rst_pubcnt", d, 8'h00);
        beat(5'd1, 12'd4, 1'b1);
        beat(5'd1, 12'd4, 1'b1);
        check("post_rst_no_early", sample_tick, 1'b0);
        beat(5'd1, 12'd4, 1'b1);
        beat(5'd1, 12'd4, 1'b1);
        check("post_rst_tick", sample_tick, 1'b1);
        rd(8'h02, d); check("post_rst_avg0_new", d, 8'h04);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
